reduce_scheduler: RTL and testbench

Round-robin controller that shares one `reduce_vector_alu` instance between R requesters. It grants one request at a time and drives the ALU `set`/`sel`/`in_len`/`en` controls. It also drives the vector-register-file read address that feeds the ALU `in` bus, then returns the scalar result over a valid/ready response channel. Only one reduction is outstanding at a time.

---
 rtl/reduce_scheduler_if.sv | 42 ++++
 rtl/reduce_scheduler.sv | 174 +++++++++++++++++
 tb/tb_reduce_scheduler.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reduce_scheduler_if.sv
// Requester, response and ALU-control bundle for reduce_scheduler.
// master = scheduler side, slave = requesters / ALU / register-file side.
interface reduce_scheduler_if #(
  parameter int unsigned BITS   = 8,
  parameter int unsigned N      = 64,
  parameter int unsigned R      = 4,
  parameter int unsigned ADDR_W = 4
);
  localparam int unsigned ID_W = $clog2(R);

  logic [R-1:0]              req;
  logic [R-1:0][1:0]         req_sel;
  logic [R-1:0][BITS-1:0]    req_len;
  logic [R-1:0][ADDR_W-1:0]  req_addr;
  logic [R-1:0]              gnt;

  logic                      resp_valid;
  logic                      resp_ready;
  logic [ID_W-1:0]           resp_id;
  logic [BITS-1:0]           resp_data;
  logic                      resp_err;

  logic [ADDR_W-1:0]         vrf_addr;
  logic                      alu_set;
  logic [1:0]                alu_sel;
  logic [BITS-1:0]           alu_len;
  logic                      alu_en;
  logic                      alu_done;
  logic [BITS-1:0]           alu_out;

  modport master (
    input  req, req_sel, req_len, req_addr, resp_ready, alu_done, alu_out,
    output gnt, resp_valid, resp_id, resp_data, resp_err,
           vrf_addr, alu_set, alu_sel, alu_len, alu_en
  );

  modport slave (
    output req, req_sel, req_len, req_addr, resp_ready, alu_done, alu_out,
    input  gnt, resp_valid, resp_id, resp_data, resp_err,
           vrf_addr, alu_set, alu_sel, alu_len, alu_en
  );
endinterface

// File: rtl/reduce_scheduler.sv
// Round-robin scheduler sharing one reduce_vector_alu among R requesters.
// Optional WAIT timeout abort is enabled by defining REDUCE_SCHED_TIMEOUT_EN.
module reduce_scheduler #(
  parameter int unsigned BITS   = 8,
  parameter int unsigned N      = 64,
  parameter int unsigned R      = 4,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  reduce_scheduler_if.master    bus
);
  localparam int unsigned ID_W = $clog2(R);
`ifdef REDUCE_SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(N + 5);
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   cur_id_q, cur_id_d;
  logic [1:0]        sel_q, sel_d;
  logic [BITS-1:0]   len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [R-1:0]      gnt_q, gnt_d;
  logic              alu_set_q, alu_set_d;
  logic              resp_valid_q, resp_valid_d;
  logic [BITS-1:0]   resp_data_q, resp_data_d;
`ifdef REDUCE_SCHED_TIMEOUT_EN
  logic              resp_err_q, resp_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

  logic              found_c;
  logic [ID_W-1:0]   win_c;
  logic [BITS-1:0]   win_len_c;
  int unsigned       idx;

  // Round-robin search starting at ptr, wrapping past R-1 to 0.
  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    idx     = 0;
    for (int unsigned i = 0; i < R; i++) begin
      idx = (32'(ptr_q) + i) % R;
      if (!found_c && bus.req[ID_W'(idx)]) begin
        found_c = 1'b1;
        win_c   = ID_W'(idx);
      end
    end
    win_len_c = (bus.req_len[win_c] > BITS'(N)) ? BITS'(N) : bus.req_len[win_c];
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cur_id_d     = cur_id_q;
    sel_d        = sel_q;
    len_d        = len_q;
    addr_d       = addr_q;
    gnt_d        = '0;
    alu_set_d    = 1'b0;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
`ifdef REDUCE_SCHED_TIMEOUT_EN
    resp_err_d   = resp_err_q;
    cnt_d        = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (found_c) begin
          cur_id_d     = win_c;
          sel_d        = bus.req_sel[win_c];
          len_d        = win_len_c;
          addr_d       = bus.req_addr[win_c];
          ptr_d        = (32'(win_c) == R - 1) ? '0 : win_c + ID_W'(1);
          gnt_d[win_c] = 1'b1;
          alu_set_d    = 1'b1;
`ifdef REDUCE_SCHED_TIMEOUT_EN
          resp_err_d   = 1'b0;
`endif
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
`ifdef REDUCE_SCHED_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = S_WAIT;
      end
      // done is only trusted here: the ALU clears it on the set edge.
      S_WAIT: begin
`ifdef REDUCE_SCHED_TIMEOUT_EN
        cnt_d = cnt_q + CNT_W'(1);
`endif
        if (bus.alu_done) begin
          resp_data_d  = bus.alu_out;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end
`ifdef REDUCE_SCHED_TIMEOUT_EN
        else if (cnt_d == CNT_W'(N + 4)) begin
          resp_data_d  = '0;
          resp_err_d   = 1'b1;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end
`endif
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      cur_id_q     <= '0;
      sel_q        <= '0;
      len_q        <= '0;
      addr_q       <= '0;
      gnt_q        <= '0;
      alu_set_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
`ifdef REDUCE_SCHED_TIMEOUT_EN
      resp_err_q   <= 1'b0;
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cur_id_q     <= cur_id_d;
      sel_q        <= sel_d;
      len_q        <= len_d;
      addr_q       <= addr_d;
      gnt_q        <= gnt_d;
      alu_set_q    <= alu_set_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
`ifdef REDUCE_SCHED_TIMEOUT_EN
      resp_err_q   <= resp_err_d;
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.alu_set    = alu_set_q;
  assign bus.alu_sel    = sel_q;
  assign bus.alu_len    = len_q;
  assign bus.vrf_addr   = addr_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = cur_id_q;
  assign bus.resp_data  = resp_data_q;
  // Enable the ALU result onto the shared bus only in the capture cycle.
  assign bus.alu_en     = (state_q == S_WAIT) && bus.alu_done;
`ifdef REDUCE_SCHED_TIMEOUT_EN
  assign bus.resp_err   = resp_err_q;
`else
  assign bus.resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_reduce_scheduler.sv
// Self-checking bench for reduce_scheduler: behavioural ALU/register file,
// round-robin and reduction reference model, directed plus random requests.
module tb_reduce_scheduler;
  localparam int unsigned BITS   = 8;
  localparam int unsigned N      = 64;
  localparam int unsigned R      = 4;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned ID_W   = $clog2(R);
  localparam int unsigned NI_W   = $clog2(N);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reduce_scheduler_if #(.BITS(BITS), .N(N), .R(R), .ADDR_W(ADDR_W)) bus ();

  reduce_scheduler #(.BITS(BITS), .N(N), .R(R), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int mdl_ptr  = 0;

  logic [N-1:0][BITS-1:0] vrf_mem [1<<ADDR_W];

  // Reference reduction on signed elements, wrapping arithmetic.
  function automatic logic [BITS-1:0] ref_reduce(input logic [1:0] sel, input int len,
                                                 input logic [N-1:0][BITS-1:0] v);
    int acc;
    int e;
    case (sel)
      2'd2:    acc = 127;
      2'd3:    acc = -128;
      default: acc = 0;
    endcase
    for (int i = 0; i < len; i++) begin
      e = int'($signed(v[NI_W'(i)]));
      case (sel)
        2'd0: acc = acc + e;
        2'd1: acc = acc | (e & 255);
        2'd2: if (e < acc) acc = e;
        default: if (e > acc) acc = e;
      endcase
    end
    return acc[BITS-1:0];
  endfunction

  function automatic int rr_pick(input logic [R-1:0] m, input int p);
    int j;
    for (int i = 0; i < int'(R); i++) begin
      j = (p + i) % int'(R);
      if (m[ID_W'(j)]) return j;
    end
    return -1;
  endfunction

  function automatic int clamp_len(input logic [BITS-1:0] l);
    return (int'(l) > int'(N)) ? int'(N) : int'(l);
  endfunction

  // Behavioural ALU: restarts on set, done in cycle len+3, result held until next set.
  logic [BITS-1:0] alu_res = '0;
  int              alu_cnt = 0;
  logic            alu_done_q = 1'b0;
  bit              alu_stall = 1'b0;
  always @(posedge clk) begin
    if (bus.alu_set) begin
      alu_res    <= ref_reduce(bus.alu_sel, int'(bus.alu_len), vrf_mem[bus.vrf_addr]);
      alu_cnt    <= int'(bus.alu_len) + 1;
      alu_done_q <= 1'b0;
    end else if (alu_cnt != 0) begin
      alu_cnt <= alu_cnt - 1;
      if (alu_cnt == 1 && !alu_stall) alu_done_q <= 1'b1;
    end
  end
  assign bus.alu_done = alu_done_q;
  assign bus.alu_out  = bus.alu_en ? alu_res : 8'hA5;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_gnt"},        32'(bus.gnt),        32'd0);
    check_eq({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
    check_eq({tag, "_resp_id"},    32'(bus.resp_id),    32'd0);
    check_eq({tag, "_resp_data"},  32'(bus.resp_data),  32'd0);
    check_eq({tag, "_resp_err"},   32'(bus.resp_err),   32'd0);
    check_eq({tag, "_alu_set"},    32'(bus.alu_set),    32'd0);
    check_eq({tag, "_alu_en"},     32'(bus.alu_en),     32'd0);
    check_eq({tag, "_vrf_addr"},   32'(bus.vrf_addr),   32'd0);
    check_eq({tag, "_alu_sel"},    32'(bus.alu_sel),    32'd0);
    check_eq({tag, "_alu_len"},    32'(bus.alu_len),    32'd0);
  endtask

  // Current cycle is cycle 0 (DUT in IDLE, req already driven).
  task automatic run_txn(input int ready_delay, input bit keep_req);
    int w;
    int l;
    int k;
    logic [ID_W-1:0] wi;
    logic [BITS-1:0] exp;
    w = rr_pick(bus.req, mdl_ptr);
    if (w < 0) begin
      check_eq("txn_no_request", 32'd0, 32'd1);
      return;
    end
    wi  = ID_W'(w);
    l   = clamp_len(bus.req_len[wi]);
    exp = ref_reduce(bus.req_sel[wi], l, vrf_mem[bus.req_addr[wi]]);
    tick();
    check_eq("gnt",      32'(bus.gnt),      32'(1) << w);
    check_eq("alu_set",  32'(bus.alu_set),  32'd1);
    check_eq("alu_len",  32'(bus.alu_len),  32'(l));
    check_eq("alu_sel",  32'(bus.alu_sel),  32'(bus.req_sel[wi]));
    check_eq("vrf_addr", 32'(bus.vrf_addr), 32'(bus.req_addr[wi]));
    mdl_ptr = (w + 1) % int'(R);
    if (!keep_req) bus.req[wi] = 1'b0;
    k = 1;
    while (!bus.resp_valid && k < 300) begin
      tick();
      k++;
    end
    check_eq("latency",   32'(k),             32'(l + 4));
    check_eq("resp_data", 32'(bus.resp_data), 32'(exp));
    check_eq("resp_id",   32'(bus.resp_id),   32'(w));
    check_eq("resp_err",  32'(bus.resp_err),  32'd0);
    repeat (ready_delay) tick();
    check_eq("resp_hold_valid", 32'(bus.resp_valid), 32'd1);
    check_eq("resp_hold_data",  32'(bus.resp_data),  32'(exp));
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    check_eq("resp_drop", 32'(bus.resp_valid), 32'd0);
    check_eq("gnt_idle",  32'(bus.gnt),        32'd0);
  endtask

  task automatic set_req(input int i, input logic [1:0] sel, input logic [BITS-1:0] len,
                         input logic [ADDR_W-1:0] addr);
    bus.req_sel[ID_W'(i)]  = sel;
    bus.req_len[ID_W'(i)]  = len;
    bus.req_addr[ID_W'(i)] = addr;
  endtask

  initial begin
    int r;
    bus.req        = '0;
    bus.req_sel    = '0;
    bus.req_len    = '0;
    bus.req_addr   = '0;
    bus.resp_ready = 1'b0;
    for (int a = 0; a < (1 << ADDR_W); a++)
      for (int e = 0; e < int'(N); e++)
        vrf_mem[ADDR_W'(a)][NI_W'(e)] = BITS'($urandom);
    vrf_mem[3][0] = 8'd5;
    vrf_mem[3][1] = 8'hFE;
    vrf_mem[3][2] = 8'd7;
    vrf_mem[5][0] = 8'h80;
    vrf_mem[5][1] = 8'hFF;

    repeat (2) tick();
    rst = 1'b0;
    check_reset_vals("reset");

    // Single sum request from requester 1, consumer stalls 5 cycles.
    set_req(1, 2'd0, 8'd3, 4'd3);
    bus.req = 4'b0010;
    run_txn(5, 1'b0);

    // Round-robin from reset: all requesting, then wrap to lone req[0].
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mdl_ptr = 0;
    for (int i = 0; i < int'(R); i++) set_req(i, 2'd0, 8'd1, ADDR_W'(i));
    bus.req = '1;
    for (int t = 0; t < 6; t++) run_txn(0, 1'b1);
    bus.req = 4'b0001;
    run_txn(0, 1'b0);

    // Boundaries: empty min, clamped or, signed max.
    set_req(2, 2'd2, 8'd0, 4'd7);
    bus.req = 4'b0100;
    run_txn(1, 1'b0);
    set_req(3, 2'd1, 8'd200, 4'd8);
    bus.req = 4'b1000;
    run_txn(0, 1'b0);
    set_req(0, 2'd3, 8'd2, 4'd5);
    bus.req = 4'b0001;
    run_txn(2, 1'b0);

    // Reset during WAIT of a long op, then a fresh op.
    set_req(0, 2'd0, 8'd10, 4'd9);
    bus.req = 4'b0001;
    repeat (3) tick();
    bus.req = '0;
    rst = 1'b1;
    tick();
    check_reset_vals("midwait_rst");
    rst = 1'b0;
    mdl_ptr = 0;
    for (int e = 0; e < int'(N); e++) vrf_mem[9][NI_W'(e)] = BITS'($urandom);
    set_req(2, 2'd3, 8'd6, 4'd9);
    bus.req = 4'b0100;
    run_txn(0, 1'b0);

`ifdef REDUCE_SCHED_TIMEOUT_EN
    begin
      int k;
      alu_stall = 1'b1;
      set_req(1, 2'd0, 8'd4, 4'd2);
      bus.req = 4'b0010;
      tick();
      bus.req = '0;
      mdl_ptr = 2;
      k = 1;
      while (!bus.resp_valid && k < 300) begin
        tick();
        k++;
      end
      check_eq("tmo_latency", 32'(k),             32'(N + 6));
      check_eq("tmo_err",     32'(bus.resp_err),  32'd1);
      check_eq("tmo_data",    32'(bus.resp_data), 32'd0);
      bus.resp_ready = 1'b1;
      tick();
      bus.resp_ready = 1'b0;
      alu_stall = 1'b0;
      set_req(3, 2'd1, 8'd5, 4'd4);
      bus.req = 4'b1000;
      run_txn(0, 1'b0);
    end
`endif

    // Random requests against the model.
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < int'(R); i++) begin
        r = int'($urandom_range(0, 9));
        set_req(i, 2'($urandom_range(0, 3)),
                (r == 0) ? 8'd0 : (r == 1) ? 8'($urandom_range(65, 255)) : 8'($urandom_range(1, N)),
                ADDR_W'($urandom_range(0, 15)));
      end
      bus.req = R'($urandom_range(1, 15));
      run_txn(int'($urandom_range(0, 3)), 1'b0);
      bus.req = '0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
